// File: rtl/s3ga_cfg_wb_bridge.sv
// Wishbone slave that queues S3GA configuration words in a FIFO and streams
// them to the fabric. It also provides control/status registers, overflow
// detection and maskable interrupts.
module s3ga_cfg_wb_bridge #(
    parameter int DEPTH    = 8,
    parameter int N_IRQ    = 3,
    parameter int ADDR_LSB = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             cfg_valid_o,
    output logic [31:0]      cfg_data_o,
    input  logic             cfg_ready_i,
    input  logic             cfg_err_i,
    output logic [N_IRQ-1:0] user_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          ack;
    logic [1:0]    idx;
    logic          req, wr, ctrl_wr, data_wr, irq_wr, flush;
    logic [CW-1:0] count;
    logic [AW-1:0] wptr, rptr;
    logic [31:0]   mem [DEPTH];
    logic          empty, full, push, pop, ovf_set, done_set;
    logic          en;
    logic [2:0]    irq_en, irq_st, irq_set, irq_clr, irq_q;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign idx = wbs_adr_i[ADDR_LSB+1:ADDR_LSB];
    assign req = wbs_cyc_i & wbs_stb_i & ~ack;
    // The master holds its request through ack, so all side effects commit on the ack cycle.
    assign wr      = ack & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign ctrl_wr = wr & (idx == 2'd0);
    assign data_wr = wr & (idx == 2'd2) & (wbs_sel_i == 4'hF);
    assign irq_wr  = wr & (idx == 2'd3) & wbs_sel_i[0];
    assign flush   = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[1];

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign cfg_valid_o = en & ~empty;
    assign cfg_data_o  = mem[rptr];
    assign pop         = cfg_valid_o & cfg_ready_i;
    // The full check uses the pre-cycle count, so a same-cycle pop cannot make room.
    assign push     = data_wr & ~full;
    assign ovf_set  = data_wr & full;
    assign done_set = pop & ~push & (count == CW'(1));

    assign irq_set = {cfg_err_i, ovf_set, done_set};
    assign irq_clr = irq_wr ? wbs_dat_i[2:0] : 3'b000;

    assign unused_ok = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

    // Single-cycle ack; it also blocks a back-to-back request.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) ack <= 1'b0;
        else            ack <= req;
    end

    // Control register. Byte lane 0 holds EN and FLUSH; lane 1 holds IRQ_EN.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            en     <= 1'b0;
            irq_en <= 3'b000;
        end else if (ctrl_wr) begin
            if (wbs_sel_i[0]) en     <= wbs_dat_i[0];
            if (wbs_sel_i[1]) irq_en <= wbs_dat_i[10:8];
        end
    end

    // FIFO storage. It is cleared on reset so the stream output starts at 0.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= wbs_dat_i;
        end
    end

    // FIFO pointers and count. FLUSH overrides any same-cycle pop.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Interrupt status. Write-1-to-clear, and a same-cycle set wins over the clear.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) irq_st <= 3'b000;
        else            irq_st <= (irq_st & ~irq_clr) | irq_set;
    end

    // Masked interrupt lines, registered one cycle behind the status.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) irq_q <= 3'b000;
        else            irq_q <= irq_st & irq_en;
    end

    for (genvar i = 0; i < N_IRQ; i++) begin : g_irq
        if (i < 3) begin : g_src
            assign user_irq[i] = irq_q[i];
        end else begin : g_tie
            assign user_irq[i] = 1'b0;
        end
    end

    // Register read mux. FLUSH always reads 0, and DATA is write-only.
    always_comb begin
        rdata = '0;
        case (idx)
            2'd0: begin
                rdata[0]    = en;
                rdata[10:8] = irq_en;
            end
            2'd1: begin
                rdata[CW-1:0] = count;
                rdata[16]     = empty;
                rdata[17]     = full;
                rdata[18]     = irq_st[1];
            end
            2'd3: rdata[2:0] = irq_st;
            default: rdata = '0;
        endcase
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = ack ? rdata : '0;
endmodule
